// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the serial-RAM arbiter and its SPI byte shifter.
package ram_arb_pkg;

   localparam logic [7:0] RAM_OP_WRITE = 8'h02;
   localparam logic [7:0] RAM_OP_READ  = 8'h03;

   localparam logic REQ_MCU = 1'b0;
   localparam logic REQ_COP = 1'b1;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StCmd,
      StAddrHi,
      StAddrLo,
      StData,
      StHold
   } ram_state_e;

endpackage

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte engine: SCK divider, bit counter and TX/RX shift registers.
// A load with lead set prepends one SCK-low half period before the first bit.
module spi_byte_shifter #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic       lead,
   input  logic [7:0] tx_byte,
   input  logic       miso,
   output logic       sck,
   output logic       mosi,
   output logic       lead_done,
   output logic       rx_done,
   output logic       byte_done,
   output logic [7:0] rx_byte
);

   localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

   logic            busy_q;
   logic            lead_q;
   logic            sck_q;
   logic [2:0]      bit_q;
   logic [7:0]      tx_q;
   logic [7:0]      rx_q;
   logic [DivW-1:0] div_q;
   logic            half_end;

   assign half_end  = (div_q == DivMax);
   assign lead_done = busy_q && lead_q && half_end;
   assign rx_done   = busy_q && !lead_q && !sck_q && half_end && (bit_q == 3'd7);
   assign byte_done = busy_q && !lead_q && sck_q && half_end && (bit_q == 3'd7);
   // Includes the bit being sampled this clk so the byte is usable on rx_done.
   assign rx_byte   = {rx_q[6:0], miso};
   assign sck       = sck_q;
   assign mosi      = tx_q[7];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         busy_q <= 1'b0;
         lead_q <= 1'b0;
         sck_q  <= 1'b0;
         bit_q  <= 3'd0;
         tx_q   <= 8'h00;
         rx_q   <= 8'h00;
         div_q  <= '0;
      end else if (load) begin
         busy_q <= 1'b1;
         lead_q <= lead;
         sck_q  <= 1'b0;
         bit_q  <= 3'd0;
         tx_q   <= tx_byte;
         div_q  <= '0;
      end else if (busy_q) begin
         if (half_end) begin
            div_q <= '0;
            if (lead_q) begin
               lead_q <= 1'b0;
            end else if (!sck_q) begin
               sck_q <= 1'b1;
               rx_q  <= {rx_q[6:0], miso};
            end else begin
               // Shifting a zero in leaves MOSI low once the last bit is out.
               sck_q <= 1'b0;
               tx_q  <= {tx_q[6:0], 1'b0};
               bit_q <= bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  busy_q <= 1'b0;
               end
            end
         end else begin
            div_q <= div_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter between MCU and coprocessor for the shared SPI serial RAM;
// sequences opcode, 16-bit address and a data burst for one requester at a time.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  req,
   input  logic [1:0]  we,
   input  logic [31:0] addr,
   input  logic [15:0] len,
   input  logic [15:0] wdata,
   output logic [1:0]  grant,
   output logic [1:0]  wr_ack,
   output logic [1:0]  rd_valid,
   output logic [1:0]  done,
   output logic [7:0]  rdata,
   output logic        ram_nss,
   output logic        ram_sck,
   output logic        ram_mosi,
   input  logic        ram_miso
);

   localparam int unsigned HoldW = (CLK_DIV > 0) ? $clog2(2 * CLK_DIV) : 1;
   localparam logic [HoldW-1:0] HoldMax = HoldW'(2 * CLK_DIV - 1);

   ram_state_e       state_q;
   logic             last_q;
   logic             gidx_q;
   logic             we_q;
   logic [15:0]      addr_q;
   logic [7:0]       cnt_q;
   logic [HoldW-1:0] hold_q;

   logic       arb_idx;
   logic       sh_load;
   logic       sh_lead;
   logic [7:0] sh_tx;
   logic [7:0] wdata_sel;
   logic       lead_done;
   logic       rx_done;
   logic       byte_done;
   logic [7:0] rx_byte;

   always_comb begin
      if (req == 2'b11) begin
         arb_idx = (last_q == REQ_COP) ? REQ_MCU : REQ_COP;
      end else begin
         arb_idx = req[0] ? REQ_MCU : REQ_COP;
      end
   end

   assign wdata_sel = gidx_q ? wdata[15:8] : wdata[7:0];

   always_comb begin
      sh_load = 1'b0;
      sh_lead = 1'b0;
      sh_tx   = 8'h00;
      unique case (state_q)
         StIdle: begin
            if (|req) begin
               sh_load = 1'b1;
               sh_lead = 1'b1;
               sh_tx   = we[arb_idx] ? RAM_OP_WRITE : RAM_OP_READ;
            end
         end
         StCmd: begin
            sh_load = byte_done;
            sh_tx   = addr_q[15:8];
         end
         StAddrHi: begin
            sh_load = byte_done;
            sh_tx   = addr_q[7:0];
         end
         StAddrLo: begin
            sh_load = byte_done;
            sh_tx   = we_q ? wdata_sel : 8'h00;
         end
         StData: begin
            sh_load = byte_done && (cnt_q != 8'd0);
            sh_tx   = we_q ? wdata_sel : 8'h00;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         last_q   <= REQ_COP;
         gidx_q   <= REQ_MCU;
         we_q     <= 1'b0;
         addr_q   <= 16'h0000;
         cnt_q    <= 8'd0;
         hold_q   <= '0;
         grant    <= 2'b00;
         wr_ack   <= 2'b00;
         rd_valid <= 2'b00;
         done     <= 2'b00;
         rdata    <= 8'h00;
         ram_nss  <= 1'b1;
      end else begin
         wr_ack   <= 2'b00;
         rd_valid <= 2'b00;
         done     <= 2'b00;
         unique case (state_q)
            StIdle: begin
               if (|req) begin
                  gidx_q  <= arb_idx;
                  last_q  <= arb_idx;
                  we_q    <= we[arb_idx];
                  addr_q  <= arb_idx ? addr[31:16] : addr[15:0];
                  cnt_q   <= (arb_idx ? len[15:8] : len[7:0]) - 8'd1;
                  grant   <= arb_idx ? 2'b10 : 2'b01;
                  ram_nss <= 1'b0;
                  state_q <= StSetup;
               end
            end
            StSetup: begin
               if (lead_done) state_q <= StCmd;
            end
            StCmd: begin
               if (byte_done) state_q <= StAddrHi;
            end
            StAddrHi: begin
               if (byte_done) state_q <= StAddrLo;
            end
            StAddrLo: begin
               if (byte_done) begin
                  state_q <= StData;
                  if (we_q) wr_ack[gidx_q] <= 1'b1;
               end
            end
            StData: begin
               if (rx_done && !we_q) begin
                  rdata            <= rx_byte;
                  rd_valid[gidx_q] <= 1'b1;
               end
               if (byte_done) begin
                  if (cnt_q == 8'd0) begin
                     state_q      <= StHold;
                     ram_nss      <= 1'b1;
                     grant        <= 2'b00;
                     done[gidx_q] <= 1'b1;
                     hold_q       <= HoldMax;
                  end else begin
                     cnt_q <= cnt_q - 8'd1;
                     if (we_q) wr_ack[gidx_q] <= 1'b1;
                  end
               end
            end
            StHold: begin
               if (hold_q == '0) begin
                  state_q <= StIdle;
               end else begin
                  hold_q <= hold_q - 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   spi_byte_shifter #(
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (sh_load),
      .lead      (sh_lead),
      .tx_byte   (sh_tx),
      .miso      (ram_miso),
      .sck       (ram_sck),
      .mosi      (ram_mosi),
      .lead_done (lead_done),
      .rx_done   (rx_done),
      .byte_done (byte_done),
      .rx_byte   (rx_byte)
   );

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural SPI RAM that logs MOSI bytes
// and serves read bytes on MISO.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [31:0] addr;
   logic [15:0] len;
   logic [15:0] wdata;
   logic [1:0]  grant;
   logic [1:0]  wr_ack;
   logic [1:0]  rd_valid;
   logic [1:0]  done;
   logic [7:0]  rdata;
   logic        ram_nss;
   logic        ram_sck;
   logic        ram_mosi;
   logic        ram_miso;

   always #5 clk = ~clk;

   ram_arbiter #(
      .CLK_DIV (2)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req),
      .we       (we),
      .addr     (addr),
      .len      (len),
      .wdata    (wdata),
      .grant    (grant),
      .wr_ack   (wr_ack),
      .rd_valid (rd_valid),
      .done     (done),
      .rdata    (rdata),
      .ram_nss  (ram_nss),
      .ram_sck  (ram_sck),
      .ram_mosi (ram_mosi),
      .ram_miso (ram_miso)
   );

   int nerr = 0;
   int nchk = 0;

   // RAM model: MOSI captured on SCK rise, MISO advanced right after each rise.
   logic [7:0] mosi_log [300];
   logic [7:0] rd_bytes [3];
   logic [7:0] rx_sh;
   int         bitcnt = 0;
   int         nbytes = 0;

   always @(negedge ram_nss or posedge ram_sck) begin
      if (ram_sck) begin
         int idx;
         rx_sh = {rx_sh[6:0], ram_mosi};
         bitcnt++;
         if (bitcnt % 8 == 0) begin
            if (nbytes < 300) mosi_log[nbytes] = rx_sh;
            nbytes++;
         end
         idx = bitcnt / 8;
         if (idx >= 3 && idx < 6) ram_miso = rd_bytes[idx-3][7 - (bitcnt % 8)];
         else ram_miso = 1'b0;
      end else begin
         bitcnt   = 0;
         nbytes   = 0;
         ram_miso = 1'b0;
      end
   end

   // Cycle monitor, sampled on the falling clock edge.
   int         cyc = 0;
   int         wa_cnt [2] = '{0, 0};
   int         rdv_cnt [2] = '{0, 0};
   int         done_cnt [2] = '{0, 0};
   logic [7:0] rd_log [64];
   int         rd_tot = 0;
   int         last_rdv_cyc = 0;
   int         last_done_cyc = 0;
   logic       gr_log [64];
   int         gr_tot = 0;
   logic [1:0] prev_grant = 2'b00;
   int         gap_log [64];
   int         gap_tot = 0;
   int         low_run = 0;
   int         high_run = 0;
   int         last_low = 0;
   logic       prev_nss = 1'b1;
   int         oh_err = 0;

   always @(negedge clk) begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (wr_ack[k]) wa_cnt[k]++;
         if (rd_valid[k]) rdv_cnt[k]++;
         if (done[k]) done_cnt[k]++;
      end
      if (rd_valid != 2'b00) begin
         if (rd_tot < 64) rd_log[rd_tot] = rdata;
         rd_tot++;
         last_rdv_cyc = cyc;
      end
      if (done != 2'b00) last_done_cyc = cyc;
      if (grant != 2'b00 && prev_grant == 2'b00) begin
         if (gr_tot < 64) gr_log[gr_tot] = grant[1];
         gr_tot++;
      end
      if ((grant & (grant - 2'b01)) != 2'b00) oh_err++;
      prev_grant = grant;
      if (!ram_nss) begin
         if (prev_nss) begin
            if (gap_tot < 64) gap_log[gap_tot] = high_run;
            gap_tot++;
         end
         low_run++;
         high_run = 0;
      end else begin
         if (!prev_nss) last_low = low_run;
         low_run = 0;
         high_run++;
      end
      prev_nss = ram_nss;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_done(input int idx, input int target, input int budget,
                            input string tag);
      bit hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         step(1);
         if (done_cnt[idx] >= target) hit = 1'b1;
      end
      chk(tag, 32'(hit), 32'd1);
   endtask

   initial begin
      int base;
      int base2;
      int gb;
      int gpb;
      int bad;
      bit hit;
      logic [7:0] exp1 [4];
      logic [7:0] exp2 [6];
      logic [7:0] exp5 [4];

      reset_n = 1'b0;
      req     = 2'b00;
      we      = 2'b00;
      addr    = 32'h0;
      len     = 16'h0;
      wdata   = 16'h0;
      rd_bytes[0] = 8'h11;
      rd_bytes[1] = 8'h22;
      rd_bytes[2] = 8'h33;
      step(3);

      chk("rst_nss", 32'(ram_nss), 32'd1);
      chk("rst_sck", 32'(ram_sck), 32'd0);
      chk("rst_mosi", 32'(ram_mosi), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'h00);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_wr_ack", 32'(wr_ack), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      reset_n = 1'b1;
      step(2);

      // MCU write, one byte.
      exp1 = '{8'h02, 8'h12, 8'h34, 8'hA5};
      base  = wa_cnt[0];
      base2 = done_cnt[0];
      req   = 2'b01;
      we    = 2'b01;
      addr  = 32'h0000_1234;
      len   = 16'h0001;
      wdata = 16'h00A5;
      step(1);
      chk("t1_grant_latency", 32'(grant), 32'd1);
      req = 2'b00;
      wait_done(0, base2 + 1, 400, "t1_done_timeout");
      step(4);
      chk("t1_nbytes", nbytes, 4);
      for (int i = 0; i < 4; i++) chk($sformatf("t1_mosi%0d", i), 32'(mosi_log[i]), 32'(exp1[i]));
      chk("t1_wr_ack_cnt", wa_cnt[0] - base, 1);
      chk("t1_done_cnt", done_cnt[0] - base2, 1);
      chk("t1_nss_low", last_low, 130);
      chk("t1_grant_after", 32'(grant), 32'd0);

      // COP read, three bytes.
      exp2 = '{8'h03, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
      base  = rd_tot;
      base2 = done_cnt[1];
      gb    = rdv_cnt[1];
      req   = 2'b10;
      we    = 2'b00;
      addr  = 32'h00FF_0000;
      len   = 16'h0300;
      step(1);
      chk("t2_grant", 32'(grant), 32'd2);
      req = 2'b00;
      wait_done(1, base2 + 1, 500, "t2_done_timeout");
      step(4);
      chk("t2_nbytes", nbytes, 6);
      for (int i = 0; i < 6; i++) chk($sformatf("t2_mosi%0d", i), 32'(mosi_log[i]), 32'(exp2[i]));
      chk("t2_rdv_cnt", rdv_cnt[1] - gb, 3);
      for (int i = 0; i < 3; i++)
         chk($sformatf("t2_rdata%0d", i), 32'(rd_log[base + i]), 32'(rd_bytes[i]));
      chk("t2_rdv_before_done", 32'(last_rdv_cyc < last_done_cyc), 32'd1);
      chk("t2_rdata_hold", 32'(rdata), 32'h33);
      chk("t2_no_wr_ack", wa_cnt[1], 0);

      // Both requesting from reset: MCU first, then alternate.
      reset_n = 1'b0;
      req     = 2'b11;
      we      = 2'b11;
      addr    = 32'h2000_1000;
      len     = 16'h0101;
      step(2);
      gb  = gr_tot;
      gpb = gap_tot;
      base2 = done_cnt[1];
      reset_n = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 1500 && !hit; i++) begin
         step(1);
         if (gr_tot >= gb + 4) hit = 1'b1;
      end
      req = 2'b00;
      chk("t3_grant_timeout", 32'(hit), 32'd1);
      wait_done(1, base2 + 2, 400, "t3_done_timeout");
      step(4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("t3_order%0d", i), 32'(gr_log[gb + i]), 32'(i % 2));
      for (int i = 1; i < 4; i++)
         chk($sformatf("t3_gap%0d", i), 32'(gap_log[gpb + i] >= 5), 32'd1);

      // len 0 MCU write: 256 data bytes, requester advances wdata after each ack.
      base  = wa_cnt[0];
      req   = 2'b01;
      we    = 2'b01;
      addr  = 32'h0000_0100;
      len   = 16'h0000;
      wdata = 16'h0000;
      step(1);
      chk("t4_grant", 32'(grant), 32'd1);
      req = 2'b00;
      hit = 1'b0;
      for (int i = 0; i < 9000 && !hit; i++) begin
         step(1);
         if (wr_ack[0]) wdata[7:0] = wdata[7:0] + 8'd1;
         if (done[0]) hit = 1'b1;
      end
      chk("t4_done_timeout", 32'(hit), 32'd1);
      step(4);
      chk("t4_wr_ack_cnt", wa_cnt[0] - base, 256);
      chk("t4_nbytes", nbytes, 259);
      bad = 0;
      for (int k = 0; k < 256; k++) if (mosi_log[3 + k] !== 8'(k)) bad++;
      chk("t4_data_bad", bad, 0);

      // Reset pulse during ADDR_HI, then a normal transaction.
      req   = 2'b01;
      we    = 2'b01;
      addr  = 32'h0000_1234;
      len   = 16'h0002;
      step(1);
      chk("t5_grant", 32'(grant), 32'd1);
      step(43);
      chk("t5_in_addr_hi", nbytes, 1);
      base2   = done_cnt[0];
      reset_n = 1'b0;
      req     = 2'b00;
      step(1);
      chk("t5_nss", 32'(ram_nss), 32'd1);
      chk("t5_sck", 32'(ram_sck), 32'd0);
      chk("t5_grant_off", 32'(grant), 32'd0);
      chk("t5_done_low", 32'(done), 32'd0);
      reset_n = 1'b1;
      step(3);
      chk("t5_no_done", done_cnt[0] - base2, 0);
      exp5 = '{8'h02, 8'hBE, 8'hEF, 8'h5A};
      addr  = 32'h0000_BEEF;
      len   = 16'h0001;
      wdata = 16'h005A;
      req   = 2'b01;
      step(1);
      chk("t5b_grant", 32'(grant), 32'd1);
      req = 2'b00;
      wait_done(0, base2 + 1, 400, "t5b_done_timeout");
      step(4);
      for (int i = 0; i < 4; i++) chk($sformatf("t5b_mosi%0d", i), 32'(mosi_log[i]), 32'(exp5[i]));

      // req dropped mid-burst: burst still completes.
      base  = wa_cnt[0];
      base2 = done_cnt[0];
      addr  = 32'h0000_4000;
      len   = 16'h0004;
      req   = 2'b01;
      step(1);
      chk("t6_grant", 32'(grant), 32'd1);
      step(100);
      req = 2'b00;
      wait_done(0, base2 + 1, 500, "t6_done_timeout");
      gb = gr_tot;
      step(10);
      chk("t6_wr_ack_cnt", wa_cnt[0] - base, 4);
      chk("t6_nbytes", nbytes, 7);
      chk("t6_done_cnt", done_cnt[0] - base2, 1);
      chk("t6_no_regrant", gr_tot - gb, 0);

      chk("grant_onehot", oh_err, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Clocked arbiter and SPI master for the shared serial RAM. It owns the RAM chip select, clock and data pins and accepts burst read/write requests from two requesters: index 0 is the MCU and index 1 is the coprocessor. Requesters are served round-robin, one whole transaction at a time. Each transaction is sequenced as opcode, 16-bit address, then N data bytes, with per-byte handshakes to the requester.

## Interface
- `CLK_DIV`, 2: clk cycles per SCK half-period; must be ≥1.
- `clk`  in  1  block clock; all state changes on posedge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req`  in  2  per-requester request level; bit 0 = MCU, bit 1 = COP.
- `we`  in  2  per-requester transaction type: 1 = write, 0 = read.
- `addr`  in  32  start addresses, packed: [15:0] = MCU, [31:16] = COP.
- `len`  in  16  byte counts, packed: [7:0] = MCU, [15:8] = COP; 0 means 256.
- `wdata`  in  16  write data, packed: [7:0] = MCU, [15:8] = COP.
- `grant`  out  2  one-hot-or-zero; high for the whole transaction.
- `wr_ack`  out  2  one-clk pulse: the granted requester's `wdata` was taken.
- `rd_valid`  out  2  one-clk pulse: `rdata` holds a new byte.
- `done`  out  2  one-clk pulse: the transaction is finished.
- `rdata`  out  8  last received read byte; shared by both requesters.
- `ram_nss`, `ram_sck`, `ram_mosi`  out  1 each  SPI master pins.
- `ram_miso`  in  1  SPI data from RAM.

## Operation
- Reset values: `ram_nss`=1, `ram_sck`=0, `ram_mosi`=0, `rdata`=0; `grant`, `wr_ack`, `rd_valid`, `done` all 0; last-served pointer = COP, so the MCU wins the first tie.
- SPI mode 0:
  - SCK idles low.
  - MOSI changes only while SCK is low; MISO is sampled on SCK rise.
  - Data is MSB first.
- States: IDLE → SETUP → CMD → ADDR_HI → ADDR_LO → DATA → HOLD → IDLE.
- IDLE, arbitration:
  - If `req` is nonzero, grant the single requester.
  - If both request, grant the one not last served.
  - Latch `we`, `addr`, `len` and the grant index.
  - Update the last-served pointer.
  - Assert `grant` and go to SETUP.
- SETUP: `ram_nss`=0 and SCK stays low for CLK_DIV clks; the first bit of the opcode is already on MOSI.
- CMD sends opcode 8'h02 (write) or 8'h03 (read). ADDR_HI sends addr[15:8]; ADDR_LO sends addr[7:0].
- DATA, write:
  - At each byte start, load the granted `wdata` into the shifter and pulse `wr_ack`.
- DATA, read:
  - MOSI is held at 0.
  - After the 8th sampled bit, update `rdata` and pulse `rd_valid` on the next clk.
- Byte counter: load with len−1 (8-bit wrap, so len 0 gives 255). Decrement at each data byte end; DATA ends when the counter is 0 at a byte end.
- HOLD:
  - `ram_nss`=1 and SCK low for 2·CLK_DIV clks.
  - Pulse `done` on the first HOLD clk.
  - Drop `grant` with `done`.
  - Return to IDLE.
- Dropping `req` mid-transaction is ignored; the burst completes. Keeping `req` high after `done` counts as a new request.
- A new request arriving during a transaction waits; there is no preemption.
- Reset asserted mid-transaction forces the reset values on the next clk edge. `ram_nss` rises immediately and no `done` is pulsed.
- The RAM must auto-increment its address internally; the block sends the address only once.

## Timing
- Grant latency: `grant` is high the clk after `req` is seen in IDLE.
- One SPI bit = 2·CLK_DIV clks; one byte = 16·CLK_DIV clks.
- `ram_nss` low time = CLK_DIV + (3+N)·16·CLK_DIV clks.
- Minimum gap between transactions = 2·CLK_DIV (HOLD) + 1 (IDLE) clks with `ram_nss` high.
- `wdata` for byte k+1 must be valid by the `wr_ack` of byte k+1, which comes 16·CLK_DIV clks after the `wr_ack` of byte k. The requester updates `wdata` after each ack.
- `rdata` holds its value until the next `rd_valid`.
- Every `wr_ack` precedes `done`. For reads, the final `rd_valid` precedes `done`.

## Structure
- Package `ram_arb_pkg` holds:
  - RAM_OP_WRITE = 8'h02 and RAM_OP_READ = 8'h03;
  - state enum;
  - requester indices REQ_MCU = 0 and REQ_COP = 1.
- Sub-module `spi_byte_shifter`, which contains:
  - the CLK_DIV divider;
  - the 3-bit bit counter;
  - the TX/RX shift registers;
  - `load`/`byte_done` strobes.
- The top level keeps the arbiter, the FSM and the byte counter.

## Test plan
- MCU write, CLK_DIV=2, addr 0x1234, len 1, wdata 0xA5 → MOSI bytes 02 12 34 A5; exactly one `wr_ack[0]`; `ram_nss` low for 130 clks; `done[0]` pulses once.
- COP read, addr 0x00FF, len 3, RAM model returns 11 22 33 → MOSI 03 00 FF 00 00 00; three `rd_valid[1]` with `rdata` 0x11, 0x22, 0x33; then `done[1]`.
- Both `req` high from reset → MCU served first, then COP. With both held continuously, grants alternate 0,1,0,1 with ≥5 idle clks of `ram_nss` high between transactions.
- `len`=0 MCU write → 256 `wr_ack` pulses and 259 bytes on MOSI.
- `reset_n` low for 1 clk in the middle of ADDR_HI → next clk shows `ram_nss`=1, `ram_sck`=0, `grant`=0, no `done`; a following request proceeds normally.
- `req[0]` dropped mid-burst (len 4) → all 4 bytes are still transferred and `done[0]` still pulses.
